lcd_char_writer: RTL and testbench

LCD_CHAR_WRITER -- requirements
Module: lcd_char_writer

---
 rtl/lcd_pkg.sv | 14 +
 rtl/lcd_char_writer_timer.sv | 27 ++
 rtl/lcd_char_writer.sv | 77 +++++++
 tb/tb_lcd_char_writer.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// lcd_pkg: controller states, HD44780 command bytes and enable timing shared by lcd_char_writer.
package lcd_pkg;
  typedef enum logic [2:0] {POWERUP, INIT, CLR_WAIT, ADDR, CHAR, HOLD} state_t;
  localparam logic [7:0] CMD_FUNC  = 8'h38;
  localparam logic [7:0] CMD_DISP  = 8'h0C;
  localparam logic [7:0] CMD_ENTRY = 8'h06;
  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_LINE1 = 8'h80;
  localparam logic [7:0] CMD_LINE2 = 8'hC0;
  localparam int E_START = 4;
  function automatic logic [7:0] init_cmd(input logic [1:0] i);
    return i == 2'd0 ? CMD_FUNC : i == 2'd1 ? CMD_DISP : i == 2'd2 ? CMD_ENTRY : CMD_CLEAR;
  endfunction
endpackage

// File: rtl/lcd_char_writer_timer.sv
// lcd_step_timer: free-running step counter with wrap, char-latch and enable-window strobes.
module lcd_step_timer
  import lcd_pkg::*;
#(
  parameter int STEP_CYCLES = 50000,
  parameter int E_CYCLES    = 25
) (
  input  logic clk,
  input  logic rst,
  output logic wrap,
  output logic latch,
  output logic e_next
);
  localparam int CW = $clog2(STEP_CYCLES);
  localparam logic [CW-1:0] LAST  = CW'(STEP_CYCLES - 1);
  localparam logic [CW-1:0] LATCH = CW'(E_START - 2);
  // window is one cycle early so the registered enable lands on E_START
  localparam logic [CW-1:0] E_ON  = CW'(E_START - 1);
  localparam logic [CW-1:0] E_OFF = CW'(E_START - 1 + E_CYCLES);
  logic [CW-1:0] cnt;
  assign wrap   = cnt == LAST;
  assign latch  = cnt == LATCH;
  assign e_next = cnt >= E_ON && cnt < E_OFF;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else cnt <= wrap ? '0 : cnt + 1'b1;
endmodule

// File: rtl/lcd_char_writer.sv
// lcd_char_writer: initialises a 16x2 character LCD and refreshes 32 characters continuously.
// LCD_HOLD_EN enables freezing the refresh in HOLD at the frame boundary while hold is high.
module lcd_char_writer
  import lcd_pkg::*;
#(
  parameter int STEP_CYCLES   = 50000,
  parameter int E_CYCLES      = 25,
  parameter int POWERUP_STEPS = 20
) (
  input  logic       clk,
  input  logic       rst,
  output logic [4:0] index,
  input  logic [7:0] char_in,
  input  logic       hold,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [7:0] lcd_data,
  output logic       ready,
  output logic       frame_done
);
`ifdef LCD_HOLD_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif
  localparam int SW = $clog2(POWERUP_STEPS + 4);
  localparam logic [SW-1:0] PU_LAST = SW'(POWERUP_STEPS - 1);
  state_t state;
  logic [SW-1:0] steps;
  logic wrap, latch, e_next, write_step;
  logic [7:0] wdata;
  lcd_step_timer #(.STEP_CYCLES(STEP_CYCLES), .E_CYCLES(E_CYCLES)) u_timer (
    .clk(clk), .rst(rst), .wrap(wrap), .latch(latch), .e_next(e_next)
  );
  assign lcd_rw = 1'b0;
  assign write_step = state inside {INIT, ADDR, CHAR};
  assign wdata = state == INIT ? init_cmd(steps[1:0]) :
                 state == ADDR ? (index[4] ? CMD_LINE2 : CMD_LINE1) : char_in;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state      <= POWERUP;
      steps      <= '0;
      index      <= '0;
      lcd_e      <= 1'b0;
      lcd_rs     <= 1'b0;
      lcd_data   <= '0;
      ready      <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      lcd_e      <= write_step && e_next;
      frame_done <= 1'b0;
      if (latch && write_step) begin
        lcd_data <= wdata;
        lcd_rs   <= state == CHAR;
      end
      if (wrap) begin
        steps <= steps + 1'b1;
        case (state)
          POWERUP:  if (steps == PU_LAST) begin state <= INIT; steps <= '0; end
          INIT:     if (steps == SW'(3)) begin state <= CLR_WAIT; steps <= '0; end
          CLR_WAIT: if (steps == SW'(1)) begin state <= ADDR; ready <= 1'b1; end
          ADDR:     state <= CHAR;
          CHAR: begin
            index <= index + 1'b1;
            if (index == 5'd15) state <= ADDR;
            else if (index == 5'd31) begin
              frame_done <= 1'b1;
              state      <= (HOLD_EN && hold) ? HOLD : ADDR;
            end
          end
          HOLD:     if (!hold) state <= ADDR;
          default:  state <= POWERUP;
        endcase
      end
    end
endmodule

// File: tb/tb_lcd_char_writer.sv
// tb_lcd_char_writer: scoreboard bench; expected bus writes are queued, a monitor pops them on each lcd_e rise.
module tb_lcd_char_writer;
  logic clk = 1'b0, rst = 1'b1, hold = 1'b0;
  logic [7:0] char_in = 8'h00;
  logic [4:0] index, idx_q = '0;
  logic lcd_e, lcd_rs, lcd_rw, ready, frame_done;
  logic [7:0] lcd_data;
  logic [8:0] q[$];
  logic [8:0] last = '0;
  int tc, checks = 0, errors = 0, fd_tc;
  bit armed = 1'b1;

  lcd_char_writer #(.STEP_CYCLES(16), .E_CYCLES(4), .POWERUP_STEPS(3)) dut (
    .clk(clk), .rst(rst), .index(index), .char_in(char_in), .hold(hold),
    .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_data(lcd_data),
    .ready(ready), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // clocks since reset release; tc%16 is the cycle within the current step
  always @(posedge clk or posedge rst) tc <= rst ? 0 : tc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at tc=%0d", name, act, exp, tc);
    end
  endtask

  task automatic wait_tc(input int t);
    int n = 0;
    do begin @(negedge clk); n++; end while (tc != t && n < 5000);
    chk("wait_tc", tc, t);
  endtask

  task automatic push_init();
    q.push_back(9'h038); q.push_back(9'h00C); q.push_back(9'h006); q.push_back(9'h001);
  endtask

  task automatic push_frame(input int ov, input int upto);
    q.push_back(9'h080);
    for (int i = 0; i <= upto; i++) begin
      if (i == 16) q.push_back(9'h0C0);
      q.push_back({1'b1, i == ov ? 8'h78 : 8'(8'h41 + i)});
    end
  endtask

  // character source with one clock of latency; one step is overridden at cycles 1 and 5
  initial forever begin
    @(posedge clk); #1;
    char_in = (armed && tc / 16 == 49 && tc % 16 >= 1) ? (tc % 16 >= 5 ? 8'h79 : 8'h78)
                                                      : 8'(8'h41 + idx_q);
    idx_q = index;
  end

  initial begin
    bit e_prev = 0, fd_prev = 0;
    int width = 0;
    logic [8:0] got;
    forever begin
      @(negedge clk);
      if (rst) begin
        e_prev = 0; fd_prev = 0; width = 0;
      end else begin
        if (lcd_e && !e_prev) begin
          got = {lcd_rs, lcd_data};
          chk("e_rise_cycle", tc % 16, 4);
          chk("rw", lcd_rw, 0);
          if (q.size() == 0) chk("write_expected", q.size(), 1);
          else chk("write", got, q.pop_front());
          last = got;
          width = 0;
        end
        if (lcd_e) width++;
        if (!lcd_e && e_prev) begin
          chk("e_width", width, 4);
          chk("bus_stable", {lcd_rs, lcd_data}, last);
        end
        if (frame_done) chk("frame_done_pulse", {fd_prev, last}, 10'h160);
        e_prev = lcd_e; fd_prev = frame_done;
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_e", lcd_e, 0);
    chk("rst_bus", {lcd_rs, lcd_rw, lcd_data}, 0);
    chk("rst_index", index, 0);
    chk("rst_flags", {ready, frame_done}, 0);
    push_init();
    push_frame(-1, 31);
    push_frame(5, 31);
    push_frame(-1, 20);
    rst = 1'b0;
    wait_tc(51);
    chk("powerup_quiet", lcd_e, 0);
    @(negedge clk);
    chk("first_e", lcd_e, 1);
    wait_tc(143);
    chk("ready_low", ready, 0);
    @(negedge clk);
    chk("ready_high", ready, 1);
    wait_tc(99 * 16 + 6);
    chk("writes_before_rst", q.size(), 0);
    rst = 1'b1;
    armed = 1'b0;
    #1;
    chk("midrst_e", lcd_e, 0);
    chk("midrst_bus", {lcd_rs, lcd_data}, 0);
    chk("midrst_index", index, 0);
    chk("midrst_flags", {ready, frame_done}, 0);
    repeat (3) @(negedge clk);
    q.delete();
    push_init();
    push_frame(-1, 31);
    q.push_back(9'h080);
    hold = 1'b1;
    rst = 1'b0;
    wait_tc(51);
    chk("replay_quiet", lcd_e, 0);
    @(negedge clk);
    chk("replay_first_e", lcd_e, 1);
    fd_tc = 0;
    for (int n = 0; n < 2000 && !frame_done; n++) @(negedge clk);
    chk("frame_done_tc", tc, 43 * 16);
    fd_tc = tc;
`ifdef LCD_HOLD_EN
    begin
      bit seen = 0;
      repeat (80) begin @(negedge clk); seen |= lcd_e; end
      chk("hold_quiet", seen, 0);
      hold = 1'b0;
    end
`else
    wait_tc(fd_tc + 4);
    chk("refresh_gap", lcd_e, 1);
`endif
    for (int n = 0; n < 200 && q.size() != 0; n++) @(negedge clk);
    chk("drain", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
